dmem_cache_responder: RTL and testbench



---
 rtl/dmem_cache_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_cache_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_responder.sv
// dmem_cache_responder: responder for the CPU data-memory port.
// Direct-mapped, one word per line, write-through, no-write-allocate cache.
// Read misses and every write go to backing memory over an initiator port
// using the same request/ready handshake as the CPU side.
// Optional: define DMEM_CACHE_STATS_EN to add hit_count/miss_count outputs.
module dmem_cache_responder #(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_rd,
    input  logic              dmem_wr,
    input  logic [31:0]       dmem_wdata,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
`ifdef DMEM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           state;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
    logic [31:0]          data_ram [NUM_LINES];
    logic                 wr_hit;    // write hit a valid line at acceptance

    // Lookup for the incoming CPU request.
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    // The outstanding transaction's address lives in mem_addr, so the fill
    // and write-update index/tag are taken from there.
    logic [IDX_W-1:0] cur_idx;
    logic [TAG_W-1:0] cur_tag;
    // Byte offset is irrelevant for word-only accesses.
    logic             unused_addr_bits;

    assign req_idx          = dmem_addr[2+IDX_W-1:2];
    assign req_tag          = dmem_addr[ADDR_W-1:2+IDX_W];
    assign hit              = valid[req_idx] && (tag_ram[req_idx] == req_tag);
    assign cur_idx          = mem_addr[2+IDX_W-1:2];
    assign cur_tag          = mem_addr[ADDR_W-1:2+IDX_W];
    assign unused_addr_bits = ^dmem_addr[1:0];

    // Control FSM: request acceptance, backing transactions, CPU response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dmem_ready <= 1'b0;
            dmem_rdata <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            valid      <= '0;
            wr_hit     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dmem_wr) begin
                        // Write takes priority over a simultaneous read.
                        mem_wr    <= 1'b1;
                        mem_addr  <= {dmem_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= dmem_wdata;
                        wr_hit    <= hit;
                        state     <= S_WRITE;
                    end else if (dmem_rd) begin
                        if (hit) begin
                            dmem_ready <= 1'b1;
                            dmem_rdata <= data_ram[req_idx];
                            state      <= S_RESP;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= {dmem_addr[ADDR_W-1:2], 2'b00};
                            state    <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        mem_rd           <= 1'b0;
                        valid[cur_idx]   <= 1'b1;
                        dmem_ready       <= 1'b1;
                        dmem_rdata       <= mem_rdata;
                        state            <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_wr     <= 1'b0;
                        dmem_ready <= 1'b1;
                        dmem_rdata <= '0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    dmem_ready <= 1'b0;
                    dmem_rdata <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays: fill on read completion, update on write-hit completion.
    always_ff @(posedge clk) begin
        if (!rst && state == S_FILL && mem_ready) begin
            tag_ram[cur_idx]  <= cur_tag;
            data_ram[cur_idx] <= mem_rdata;
        end else if (!rst && state == S_WRITE && mem_ready && wr_hit) begin
            data_ram[cur_idx] <= mem_wdata;
        end
    end

`ifdef DMEM_CACHE_STATS_EN
    // Read hit/miss counters, bumped on the acceptance cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_IDLE && !dmem_wr && dmem_rd) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_cache_responder.sv
// Self-checking bench for dmem_cache_responder: directed cases plus random
// traffic, scored against a behavioural cache model and a backing memory.
module tb_dmem_cache_responder;
    localparam int NL = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] dmem_addr = '0;
    logic          dmem_rd = 1'b0;
    logic          dmem_wr = 1'b0;
    logic [31:0]   dmem_wdata = '0;
    logic [31:0]   dmem_rdata;
    logic          dmem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
`ifdef DMEM_CACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    always #5 clk = ~clk;

    dmem_cache_responder #(.NUM_LINES(NL), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DMEM_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // kind: 0 = hit (no backing txn), 1 = one backing read, 2 = one backing write
    typedef struct {
        logic [31:0] rdata;
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          req_cycle = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          fixed_lat = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;

    // Reference model state.
    logic [31:0]  ref_mem [int unsigned];
    logic [31:0]  bmem    [int unsigned];
    bit           ref_valid [NL];
    int unsigned  ref_tag   [NL];
    int           ref_hits = 0;
    int           ref_misses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_init(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : word_init(w);
    endfunction

    function automatic logic [31:0] bmem_rd(input int unsigned w);
        return bmem.exists(w) ? bmem[w] : word_init(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: serves one request at a time with random or fixed latency,
    // abandons a request the DUT drops.
    initial begin
        int lat;
        bit ab;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && (mem_rd || mem_wr)) begin
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                ab  = 1'b0;
                for (int i = 1; i < lat; i++) begin
                    @(negedge clk);
                    if (rst || !(mem_rd || mem_wr)) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    if (mem_addr[1:0] != 2'b00) begin
                        errors++;
                        $display("FAIL mem_addr_align: got %h expected low bits 00", mem_addr);
                    end
                    last_addr = mem_addr;
                    if (mem_wr) begin
                        bmem[mem_addr >> 2] = mem_wdata;
                        last_wdata = mem_wdata;
                        wr_cnt++;
                    end else begin
                        mem_rdata = bmem_rd(mem_addr >> 2);
                        rd_cnt++;
                    end
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: pops an expectation for every dmem_ready pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_rd && mem_wr) begin
                errors++;
                $display("FAIL rd_wr_overlap: got mem_rd=1 mem_wr=1 expected at most one");
            end
            if (dmem_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=1 expected no response");
                end else begin
                    e = sb.pop_front();
                    chk("rdata", dmem_rdata, e.rdata);
                    chk("mem_rd_txns", rd_cnt, (e.kind == 1) ? 32'd1 : 32'd0);
                    chk("mem_wr_txns", wr_cnt, (e.kind == 2) ? 32'd1 : 32'd0);
                    if (e.kind != 0) chk("mem_addr", last_addr, e.addr);
                    if (e.kind == 2) chk("mem_wdata", last_wdata, e.wdata);
                    if (e.kind == 0) chk("hit_latency", cyc - req_cycle, 32'd1);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Issue one CPU request; the model decides hit/miss and the expected word.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int unsigned w, idx, tg;
        bit          done;
        w   = a >> 2;
        idx = w % NL;
        tg  = w / NL;
        e.addr  = {a[31:2], 2'b00};
        e.wdata = wd;
        if (wr) begin
            e.kind  = 2;
            e.rdata = '0;
            ref_mem[w] = wd;
        end else begin
            e.rdata = ref_rd(w);
            if (ref_valid[idx] && ref_tag[idx] == tg) begin
                e.kind = 0;
                ref_hits++;
            end else begin
                e.kind = 1;
                ref_misses++;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        dmem_addr  = a;
        dmem_wr    = wr;
        dmem_rd    = rd;
        dmem_wdata = wd;
        req_cycle  = cyc;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dmem_ready) begin
                done = 1'b1;
                break;
            end
        end
        dmem_rd = 1'b0;
        dmem_wr = 1'b0;
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL ready_timeout: got no ready within 200 cycles for addr %h expected a response", a);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dmem_rd = 1'b0;
        dmem_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        rd_cnt = 0;
        wr_cnt = 0;
    endtask

    task automatic chk_stats(input string name);
`ifdef DMEM_CACHE_STATS_EN
        chk({name, "_hit_count"},  hit_count,  ref_hits);
        chk({name, "_miss_count"}, miss_count, ref_misses);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    initial begin
        bit          seen;
        int unsigned r;
        logic [31:0] a;

        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_dmem_ready", dmem_ready, 32'd0);
        chk("rst_dmem_rdata", dmem_rdata, 32'd0);
        chk("rst_mem_rd", mem_rd, 32'd0);
        chk("rst_mem_wr", mem_wr, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk_stats("rst");

        // Read miss then hit, backing latency 3.
        fixed_lat = 3;
        bmem[32'h40 >> 2]    = 32'hDEAD_BEEF;
        ref_mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        chk_stats("miss_hit");

        // Write hit, then read the updated line.
        do_req(1'b1, 1'b0, 32'h40, 32'h1234_5678);
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        // Write miss does not allocate.
        do_req(1'b1, 1'b0, 32'h80, 32'hAAAA_0001);
        do_req(1'b0, 1'b1, 32'h80, 32'h0);
        // Conflict eviction at index 0.
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        do_req(1'b0, 1'b1, 32'h80, 32'h0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        // Simultaneous rd+wr: write wins.
        do_req(1'b1, 1'b1, 32'h10, 32'h5555_AAAA);
        do_req(1'b0, 1'b1, 32'h13, 32'h0);

        // Random traffic over 4 tags x 16 indices.
        fixed_lat = 0;
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 3) * 64 + $urandom_range(0, NL - 1) * 4 + $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 6)      do_req(1'b0, 1'b1, a, $urandom);
            else if (r < 9) do_req(1'b1, 1'b0, a, $urandom);
            else            do_req(1'b1, 1'b1, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk_stats("random");

        // Reset in the middle of a fill.
        do_reset();
        chk_stats("after_rst");
        fixed_lat = 50;
        @(negedge clk);
        dmem_addr = 32'h200;
        dmem_rd   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk("fill_started", seen, 32'd1);
        rst     = 1'b1;
        dmem_rd = 1'b0;
        @(negedge clk);
        chk("mem_rd_after_rst", mem_rd, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        repeat (8) @(negedge clk);
        fixed_lat = 0;
        do_req(1'b0, 1'b1, 32'h200, 32'h0);
        chk_stats("post_abort");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
